mem_arbiter: RTL

Shares the single byte-lane memory port (the `mem` width adapter in front of the packet `sram`) among NUM_REQ pipeline requesters, e.g. the packet parser (reads) and the header modifier (writes). It accepts one request at a time, runs exactly one memory access, returns read data with a one-cycle acknowledge, and rotates priority round-robin. It sits between the pipeline stages and the `mem` adapter's `ce/we/addr_i/width_i/data_i/data_o` port.

---
 rtl/mem_arb_pkg.sv | 36 +++
 rtl/rr_pick.sv | 33 +++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter.
// The alignment check is used only when MEM_ARB_ERR_EN is defined.
package mem_arb_pkg;

    localparam int unsigned ADDR_BUS  = 32;
    localparam int unsigned DATA_BUS  = 32;
    localparam int unsigned WIDTH_BUS = 4;

    localparam logic [WIDTH_BUS-1:0] WIDTH_BYTE = WIDTH_BUS'(1);
    localparam logic [WIDTH_BUS-1:0] WIDTH_HALF = WIDTH_BUS'(2);
    localparam logic [WIDTH_BUS-1:0] WIDTH_WORD = WIDTH_BUS'(4);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                 we;
        logic [ADDR_BUS-1:0]  addr;
        logic [WIDTH_BUS-1:0] width;
        logic [DATA_BUS-1:0]  data;
    } mem_req_t;

    // Natural alignment: only the two low address bits matter.
    function automatic logic is_aligned(input logic [1:0] addr_lo, input logic [WIDTH_BUS-1:0] width);
        case (width)
            WIDTH_BYTE: return 1'b1;
            WIDTH_HALF: return ~addr_lo[0];
            WIDTH_WORD: return (addr_lo == 2'b00);
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr_i, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               valid_c
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        grant_c  = '0;
        idx_c    = '0;
        valid_c  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand     = (32'(ptr_i) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!valid_c && req_i[cand_idx]) begin
                valid_c           = 1'b1;
                grant_c[cand_idx] = 1'b1;
                idx_c             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the byte-lane memory adapter port among NUM_REQ requesters.
// Optional misalignment reject enabled by defining MEM_ARB_ERR_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ*ADDR_BUS-1:0]   req_addr_i,
    input  logic [NUM_REQ*WIDTH_BUS-1:0]  req_width_i,
    input  logic [NUM_REQ*DATA_BUS-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]            ack_o,
    output logic [DATA_BUS-1:0]           rdata_o,
    output logic [NUM_REQ-1:0]            err_o,
    output logic                          mem_ce_o,
    output logic                          mem_we_o,
    output logic [ADDR_BUS-1:0]           mem_addr_o,
    output logic [WIDTH_BUS-1:0]          mem_width_o,
    output logic [DATA_BUS-1:0]           mem_data_o,
    input  logic [DATA_BUS-1:0]           mem_data_i
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_e         state_q, state_d;
    mem_req_t           req_q, req_d;
    logic [NUM_REQ-1:0] win_oh_q, win_oh_d;
    logic [IDX_W-1:0]   win_idx_q, win_idx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic               ce_q, ce_d;
    logic               we_q, we_d;
    logic               resp_ld_q, resp_ld_d;

    logic [NUM_REQ-1:0] pick_grant_c;
    logic [IDX_W-1:0]   pick_idx_c;
    logic               pick_valid_c;
    mem_req_t           sel_req_c;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .grant_c (pick_grant_c),
        .idx_c   (pick_idx_c),
        .valid_c (pick_valid_c)
    );

    // Field mux for the current round-robin winner.
    always_comb begin
        sel_req_c = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (pick_grant_c[k]) begin
                sel_req_c.we    = req_we_i[k];
                sel_req_c.addr  = req_addr_i[ADDR_BUS*k +: ADDR_BUS];
                sel_req_c.width = req_width_i[WIDTH_BUS*k +: WIDTH_BUS];
                sel_req_c.data  = req_data_i[DATA_BUS*k +: DATA_BUS];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        win_oh_d  = win_oh_q;
        win_idx_d = win_idx_q;
        rr_ptr_d  = rr_ptr_q;
        ack_d     = '0;
        err_d     = '0;
        ce_d      = 1'b0;
        we_d      = 1'b0;
        resp_ld_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid_c) begin
                    req_d     = sel_req_c;
                    win_oh_d  = pick_grant_c;
                    win_idx_d = pick_idx_c;
`ifdef MEM_ARB_ERR_EN
                    if (!is_aligned(sel_req_c.addr[1:0], sel_req_c.width)) begin
                        state_d = ST_RESP;
                        err_d   = pick_grant_c;
                    end else begin
                        state_d = ST_ACCESS;
                        ce_d    = 1'b1;
                        we_d    = sel_req_c.we;
                    end
`else
                    state_d = ST_ACCESS;
                    ce_d    = 1'b1;
                    we_d    = sel_req_c.we;
`endif
                end
            end
            ST_ACCESS: begin
                state_d   = ST_RESP;
                ack_d     = win_oh_q;
                resp_ld_d = ~req_q.we;
            end
            ST_RESP: begin
                state_d  = ST_IDLE;
                rr_ptr_d = (win_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_q + IDX_W'(1);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            win_oh_q  <= '0;
            win_idx_q <= '0;
            rr_ptr_q  <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            ce_q      <= 1'b0;
            we_q      <= 1'b0;
            resp_ld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            win_oh_q  <= win_oh_d;
            win_idx_q <= win_idx_d;
            rr_ptr_q  <= rr_ptr_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            ce_q      <= ce_d;
            we_q      <= we_d;
            resp_ld_q <= resp_ld_d;
        end
    end

    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign mem_ce_o    = ce_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = req_q.addr;
    assign mem_width_o = req_q.width;
    assign mem_data_o  = req_q.data;

    // Adapter load data arrives in the response cycle and is forwarded as-is.
    assign rdata_o = resp_ld_q ? mem_data_i : '0;

endmodule
